// File: rtl/procesor_io.sv
// Multi-cycle accumulator core: fetches from a synchronous ROM, works on a synchronous RAM,
// keeps Z/C flags and exchanges words through valid/ready handshaked input/output ports.
module procesor_io #(
  parameter int DATA_W   = 16,
  parameter int RAM_SIZE = 10,
  parameter int ROM_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ROM_SIZE-1:0] rom_addr,
  input  logic [15:0]         instr,
  output logic [RAM_SIZE-1:0] ram_addr,
  output logic                ram_we,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   data_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_IO_IN, S_IO_OUT, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_STA = 4'h2, OP_ADD = 4'h3,
    OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
    OP_LDI = 4'h8, OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_JC  = 4'hB,
    OP_IN  = 4'hC, OP_OUT = 4'hD, OP_SH  = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  state_e              state_q, state_d;
  opcode_e             op_q, op_d;
  logic [ROM_SIZE-1:0] pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                z_q, z_d;
  logic                c_q, c_d;

  opcode_e             opcode;
  logic [11:0]         operand;
  logic [ROM_SIZE-1:0] target;
  logic [DATA_W-1:0]   imm;
  logic [DATA_W:0]     sum;
  logic                acc_wr;
  logic [DATA_W-1:0]   acc_new;

  assign opcode  = opcode_e'(instr[15:12]);
  assign operand = instr[11:0];
  assign target  = operand[ROM_SIZE-1:0];
  assign sum     = {1'b0, acc_q} + {1'b0, ram_rdata};

  // The 12-bit immediate is zero-extended or truncated to the accumulator width.
  if (DATA_W > 12) begin : g_imm_ext
    assign imm = {{(DATA_W-12){1'b0}}, operand};
  end else begin : g_imm_trunc
    assign imm = operand[DATA_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_d = S_EXEC;
          OP_IN:   state_d = S_IO_IN;
          OP_OUT:  state_d = S_IO_OUT;
          OP_HLT:  state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_EXEC:   state_d = S_FETCH;
      S_IO_IN:  if (in_valid)  state_d = S_FETCH;
      S_IO_OUT: if (out_ready) state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Strobes are decoded from the state alone, so an asynchronous reset clears them at once.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_DECODE: begin
        ram_addr = operand[RAM_SIZE-1:0];
        ram_we   = (opcode == OP_STA);
      end
      S_IO_IN:  in_ready  = 1'b1;
      S_IO_OUT: out_valid = 1'b1;
      S_HALT:   halted    = 1'b1;
      default: ;
    endcase
  end

  assign rom_addr  = pc_q;
  assign ram_wdata = acc_q;
  assign data_out  = dout_q;

  // NOTE: every combinational output gets a default first, so no latch can be inferred.
  always_comb begin
    pc_d    = pc_q;
    op_d    = op_q;
    dout_d  = dout_q;
    c_d     = c_q;
    z_d     = z_q;
    acc_d   = acc_q;
    acc_wr  = 1'b0;
    acc_new = acc_q;
    case (state_q)
      S_DECODE: begin
        op_d = opcode;
        pc_d = pc_q + 1'b1;
        case (opcode)
          OP_JMP: pc_d = target;
          OP_JZ:  if (z_q) pc_d = target;
          OP_JC:  if (c_q) pc_d = target;
          OP_LDI: begin
            acc_wr  = 1'b1;
            acc_new = imm;
          end
          OP_SH: begin
            acc_wr = 1'b1;
            if (operand[0]) begin
              c_d     = acc_q[0];
              acc_new = acc_q >> 1;
            end else begin
              c_d     = acc_q[DATA_W-1];
              acc_new = acc_q << 1;
            end
          end
          OP_OUT:  dout_d = acc_q;
          default: ;
        endcase
      end
      S_EXEC: begin
        acc_wr = 1'b1;
        case (op_q)
          OP_LDA: acc_new = ram_rdata;
          OP_ADD: {c_d, acc_new} = sum;
          OP_SUB: begin
            acc_new = acc_q - ram_rdata;
            c_d     = (acc_q < ram_rdata);
          end
          OP_AND:  acc_new = acc_q & ram_rdata;
          OP_OR:   acc_new = acc_q | ram_rdata;
          OP_XOR:  acc_new = acc_q ^ ram_rdata;
          default: acc_wr  = 1'b0;
        endcase
      end
      S_IO_IN: begin
        if (in_valid) begin
          acc_wr  = 1'b1;
          acc_new = data_in;
        end
      end
      default: ;
    endcase
    if (acc_wr) begin
      acc_d = acc_new;
      z_d   = (acc_new == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= '0;
      op_q   <= OP_NOP;
      acc_q  <= '0;
      dout_q <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      op_q   <= op_d;
      acc_q  <= acc_d;
      dout_q <= dout_d;
      z_q    <= z_d;
      c_q    <= c_d;
    end
  end

endmodule

// File: tb/tb_procesor_io.sv
// Bench for procesor_io: ROM/RAM models, handshake responders, a single-instruction vector
// table, directed multi-cycle scenarios and random programs checked against an ISA-level model.
module tb_procesor_io;

  logic        clk, rst;
  logic [7:0]  rom_addr;
  logic [15:0] instr;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata, ram_rdata, data_in, data_out;
  logic        in_valid, in_ready, out_valid, out_ready, halted;

  procesor_io #(.DATA_W(16), .RAM_SIZE(10), .ROM_SIZE(8)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .instr(instr),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rom [256];
  logic [15:0] ram [1024];
  logic [15:0] ram_init [1024];

  always @(posedge clk) instr <= rom[rom_addr];

  // The RAM reloads its initial image while reset is held.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= ram_init[i];
    end else begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  logic [15:0] in_data [64];
  int          in_delay [64];
  int          out_delay [64];
  logic [15:0] got_outs [$];

  initial begin : in_resp
    int idx, w;
    idx = 0; w = 0; in_valid = 1'b0; data_in = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        idx = 0; w = 0; in_valid = 1'b0;
      end else if (in_ready) begin
        if (w >= in_delay[idx]) begin
          in_valid = 1'b1; data_in = in_data[idx];
        end else begin
          in_valid = 1'b0; data_in = 16'($urandom); w++;
        end
      end else begin
        if (in_valid) begin idx = (idx + 1) % 64; w = 0; end
        in_valid = 1'b0;
      end
    end
  end

  initial begin : out_resp
    int idx, w;
    idx = 0; w = 0; out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        idx = 0; w = 0; out_ready = 1'b0; got_outs.delete();
      end else if (out_valid) begin
        if (w >= out_delay[idx]) begin
          out_ready = 1'b1; got_outs.push_back(data_out);
        end else begin
          out_ready = 1'b0; w++;
        end
      end else begin
        if (out_ready) begin idx = (idx + 1) % 64; w = 0; end
        out_ready = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_vec, n_bad;
  int cyc, we_cnt, ov_cnt, ir_cnt;
  bit seen [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_blank();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    for (int i = 0; i < 1024; i++) ram_init[i] = '0;
    for (int i = 0; i < 64; i++) begin
      in_data[i] = '0; in_delay[i] = 0; out_delay[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic sample();
    if (ram_we)    we_cnt++;
    if (out_valid) ov_cnt++;
    if (in_ready)  ir_cnt++;
    seen[rom_addr] = 1'b1;
  endtask

  // Counts cycles from reset release until halted shows, tracking strobes along the way.
  task automatic run_to_halt(input string name, input int budget);
    cyc = 0; we_cnt = 0; ov_cnt = 0; ir_cnt = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    sample();
    while (!halted && cyc < budget) begin
      @(negedge clk);
      cyc++;
      sample();
    end
    check({name, " halted"}, 32'(halted), 32'd1);
  endtask

  // ISA-level reference: interprets the ROM image instruction by instruction.
  int m_acc, m_cyc;
  int m_ram [1024];
  int exp_outs [$];

  task automatic model_run();
    int pc, z, c, ii, oi, ins, op, opd, ra, sum;
    bit wr;
    pc = 0; m_acc = 0; z = 0; c = 0; ii = 0; oi = 0; m_cyc = 0;
    exp_outs.delete();
    for (int k = 0; k < 1024; k++) m_ram[k] = int'(ram_init[k]);
    for (int step = 0; step < 512; step++) begin
      ins = int'(rom[pc]);
      op  = ins / 4096;
      opd = ins % 4096;
      ra  = opd % 1024;
      pc  = (pc + 1) % 256;
      wr  = 1'b1;
      m_cyc += 2;
      case (op)
        1: begin m_acc = m_ram[ra]; m_cyc += 1; end
        2: begin m_ram[ra] = m_acc; wr = 1'b0; end
        3: begin sum = m_acc + m_ram[ra]; c = (sum > 65535) ? 1 : 0; m_acc = sum % 65536; m_cyc += 1; end
        4: begin c = (m_acc < m_ram[ra]) ? 1 : 0; m_acc = (m_acc - m_ram[ra] + 65536) % 65536; m_cyc += 1; end
        5: begin m_acc = m_acc & m_ram[ra]; m_cyc += 1; end
        6: begin m_acc = m_acc | m_ram[ra]; m_cyc += 1; end
        7: begin m_acc = m_acc ^ m_ram[ra]; m_cyc += 1; end
        8: m_acc = opd;
        9: begin pc = opd % 256; wr = 1'b0; end
        10: begin if (z != 0) pc = opd % 256; wr = 1'b0; end
        11: begin if (c != 0) pc = opd % 256; wr = 1'b0; end
        12: begin m_acc = int'(in_data[ii]); m_cyc += 1 + in_delay[ii]; ii++; end
        13: begin exp_outs.push_back(m_acc); m_cyc += 1 + out_delay[oi]; oi++; wr = 1'b0; end
        14: begin
          if (opd % 2 == 1) begin c = m_acc % 2; m_acc = m_acc / 2; end
          else begin c = (m_acc >= 32768) ? 1 : 0; m_acc = (m_acc * 2) % 65536; end
        end
        15: break;
        default: wr = 1'b0;
      endcase
      if (wr) z = (m_acc == 0) ? 1 : 0;
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_acc;
    bit          exp_c;
    bit          exp_z;
  } vec_t;

  vec_t tbl [20];
  vec_t v;
  int   exp_pc, exp_cyc, t;
  logic [3:0]  rop;
  logic [11:0] ropd;

  initial begin
    n_vec = 0; n_bad = 0;
    rst = 1'b0;

    // LDA 0 loads a, the tested instruction uses b (RAM[1], or its own operand), then
    // JC/JZ route to one of four HLTs so the final PC encodes the flags.
    tbl[0]  = '{4'h3, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    tbl[1]  = '{4'h3, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    tbl[2]  = '{4'h3, 16'h8000, 16'h8001, 16'h0001, 1'b1, 1'b0};
    tbl[3]  = '{4'h4, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b0};
    tbl[4]  = '{4'h4, 16'h0007, 16'h0007, 16'h0000, 1'b0, 1'b1};
    tbl[5]  = '{4'h4, 16'h0009, 16'h0002, 16'h0007, 1'b0, 1'b0};
    tbl[6]  = '{4'h5, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0};
    tbl[7]  = '{4'h6, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0};
    tbl[8]  = '{4'h7, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b1};
    tbl[9]  = '{4'h7, 16'h00FF, 16'hFFFF, 16'hFF00, 1'b0, 1'b0};
    tbl[10] = '{4'h1, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[11] = '{4'h8, 16'h1234, 16'h8001, 16'h0001, 1'b0, 1'b0};
    tbl[12] = '{4'h8, 16'h0000, 16'h0FFF, 16'h0FFF, 1'b0, 1'b0};
    tbl[13] = '{4'h8, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[14] = '{4'hE, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b1};
    tbl[15] = '{4'hE, 16'h0001, 16'h0000, 16'h0002, 1'b0, 1'b0};
    tbl[16] = '{4'hE, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b1};
    tbl[17] = '{4'hE, 16'h8001, 16'h0001, 16'h4000, 1'b1, 1'b0};
    tbl[18] = '{4'h0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[19] = '{4'h2, 16'h0042, 16'h0000, 16'h0042, 1'b0, 1'b0};

    for (int i = 0; i < 20; i++) begin
      v = tbl[i];
      load_blank();
      ram_init[0] = v.a;
      ram_init[1] = v.b;
      rom[0] = 16'h1000;
      case (v.op)
        4'h8:    rom[1] = {v.op, v.b[11:0]};
        4'hE:    rom[1] = {v.op, 11'b0, v.b[0]};
        default: rom[1] = {v.op, 12'h001};
      endcase
      rom[2] = 16'hB008;
      rom[3] = 16'hA006;
      rom[8] = 16'hA00C;
      do_reset();
      run_to_halt($sformatf("vec%0d", i), 40);
      exp_pc  = v.exp_c ? (v.exp_z ? 13 : 10) : (v.exp_z ? 7 : 5);
      exp_cyc = 3 + ((v.op == 4'h1 || (v.op >= 4'h3 && v.op <= 4'h7)) ? 3 : 2) + 6;
      check($sformatf("vec%0d acc", i), 32'(ram_wdata), 32'(v.exp_acc));
      check($sformatf("vec%0d flags/pc", i), 32'(rom_addr), 32'(exp_pc));
      check($sformatf("vec%0d cycles", i), 32'(cyc), 32'(exp_cyc));
    end

    // Output back-pressure, first aborted by an asynchronous reset mid-handshake.
    load_blank();
    rom[0] = 16'h8005; rom[1] = 16'h2003; rom[2] = 16'h8007;
    rom[3] = 16'h3003; rom[4] = 16'hD000; rom[5] = 16'hF000;
    out_delay[0] = 1000;
    do_reset();
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("abort out_valid seen", 32'(out_valid), 32'd1);
    check("abort data_out before reset", 32'(data_out), 32'h000C);
    #2 rst = 1'b0;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst halted", 32'(halted), 32'd0);
    check("rst ram_we", 32'(ram_we), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst data_out", 32'(data_out), 32'd0);
    check("rst rom_addr", 32'(rom_addr), 32'd0);
    check("rst ram_wdata", 32'(ram_wdata), 32'd0);
    out_delay[0] = 4;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("bp first fetch addr", 32'(rom_addr), 32'd0);
    run_to_halt("bp", 60);
    check("bp cycles", 32'(cyc), 32'd18);
    check("bp ram_we cycles", 32'(we_cnt), 32'd1);
    check("bp out_valid cycles", 32'(ov_cnt), 32'd5);
    check("bp out count", 32'(got_outs.size()), 32'd1);
    if (got_outs.size() > 0) check("bp data_out", 32'(got_outs[0]), 32'h000C);
    check("bp ram[3]", 32'(ram[3]), 32'd5);
    check("bp acc", 32'(ram_wdata), 32'h000C);

    // Carry then zero flag steer two jumps; second pass leaves C clear.
    for (int pass = 0; pass < 2; pass++) begin
      load_blank();
      ram_init[0] = 16'hFFFF;
      ram_init[1] = (pass == 0) ? 16'h0001 : 16'h0000;
      rom[0] = 16'h1000; rom[1] = 16'h3001; rom[2] = 16'hB020;
      rom[8'h20] = 16'hA030;
      do_reset();
      run_to_halt($sformatf("flags%0d", pass), 40);
      check($sformatf("flags%0d acc", pass), 32'(ram_wdata), (pass == 0) ? 32'h0 : 32'hFFFF);
      check($sformatf("flags%0d fetched 0x20", pass), 32'(seen[8'h20]), (pass == 0) ? 32'd1 : 32'd0);
      check($sformatf("flags%0d fetched 0x30", pass), 32'(seen[8'h30]), (pass == 0) ? 32'd1 : 32'd0);
      check($sformatf("flags%0d final pc", pass), 32'(rom_addr), (pass == 0) ? 32'h31 : 32'h04);
    end

    // Input handshake with five idle cycles, then echo through OUT.
    load_blank();
    rom[0] = 16'hC000; rom[1] = 16'hD000;
    in_delay[0] = 5; in_data[0] = 16'hA5A5;
    do_reset();
    run_to_halt("in", 40);
    check("in in_ready cycles", 32'(ir_cnt), 32'd6);
    check("in acc", 32'(ram_wdata), 32'hA5A5);
    check("in cycles", 32'(cyc), 32'd13);
    check("in out count", 32'(got_outs.size()), 32'd1);
    if (got_outs.size() > 0) check("in data_out", 32'(got_outs[0]), 32'hA5A5);

    // PC wrap: JMP 0xFF (junk in operand[11:8]) then NOP at 0xFF.
    load_blank();
    rom[0] = 16'h9AFF; rom[8'hFF] = 16'h0000;
    do_reset();
    check("wrap cycle0 addr", 32'(rom_addr), 32'h00);
    repeat (2) @(negedge clk);
    check("wrap jump addr", 32'(rom_addr), 32'hFF);
    repeat (2) @(negedge clk);
    check("wrap next addr", 32'(rom_addr), 32'h00);

    // Random forward-only programs against the ISA model.
    for (int p = 0; p < 40; p++) begin
      load_blank();
      for (int k = 0; k < 16; k++) ram_init[k] = 16'($urandom);
      for (int k = 0; k < 64; k++) begin
        in_data[k]   = 16'($urandom);
        in_delay[k]  = $urandom_range(0, 3);
        out_delay[k] = $urandom_range(0, 3);
      end
      for (int i = 0; i < 24; i++) begin
        rop = 4'($urandom_range(0, 14));
        case (rop)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7:
            ropd = {2'($urandom), 6'b0, 4'($urandom)};
          4'h9, 4'hA, 4'hB:
            ropd = {4'($urandom), 8'($urandom_range(i + 1, 24))};
          default: ropd = 12'($urandom);
        endcase
        rom[i] = {rop, ropd};
      end
      model_run();
      do_reset();
      run_to_halt($sformatf("rand%0d", p), m_cyc + 20);
      check($sformatf("rand%0d cycles", p), 32'(cyc), 32'(m_cyc));
      check($sformatf("rand%0d acc", p), 32'(ram_wdata), 32'(m_acc));
      check($sformatf("rand%0d out count", p), 32'(got_outs.size()), 32'(exp_outs.size()));
      for (int k = 0; k < got_outs.size() && k < exp_outs.size(); k++)
        check($sformatf("rand%0d out%0d", p, k), 32'(got_outs[k]), 32'(exp_outs[k]));
      for (int k = 0; k < 16; k++)
        check($sformatf("rand%0d ram[%0d]", p, k), 32'(ram[k]), 32'(m_ram[k]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
